sram_access_ctrl: RTL and testbench
===================================

SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 4: cycles per SRAM half-word phase; legal range 2..15.
REQ-002 Parameter ADDR_BASE, default 1024: CPU byte address mapped to SRAM word 0.
REQ-003 Parameter SRAM_AW, default 18: SRAM half-word address width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 MEM_R_EN  in  1  load request from the EXE-stage register outputs.
REQ-007 MEM_W_EN  in  1  store request from the EXE-stage register outputs.
REQ-008 ALU_Res  in  32  CPU byte address.
REQ-009 Val_Rm  in  32  store data.
REQ-010 Rdata  out  32  load result.
REQ-011 ready  out  1  one-cycle pulse marking access completion.
REQ-012 freeze  out  1  pipeline hold, driven to the en/clr logic of the stage registers (en = ~freeze).
REQ-013 SRAM_ADDR  out  SRAM_AW  half-word address.
REQ-014 SRAM_WDATA  out  16  write half-word.
REQ-015 SRAM_RDATA  in  16  read half-word.
REQ-016 SRAM_WE_N  out  1  active-low write strobe.

Function
REQ-017 FSM states: IDLE, LO, HI, DONE.
REQ-018 IDLE: if MEM_W_EN or MEM_R_EN, capture address, data and op, clear the wait counter, go to LO; otherwise stay in IDLE.
REQ-019 Simultaneous MEM_R_EN and MEM_W_EN: treat as a write; no load result is produced.
REQ-020 Word index = (captured ALU_Res - ADDR_BASE) >> 2, using 32-bit unsigned subtraction.
REQ-021 SRAM_ADDR = {word index[SRAM_AW-2:0], phase}, with phase 0 in LO and 1 in HI; upper bits are discarded, so addresses wrap.
REQ-022 LO/HI timing:
- The counter increments every cycle.
- When the counter reaches WAIT_CYCLES-1, the counter clears and the FSM advances: LO to HI, HI to DONE.
REQ-023 Access latency: 2*WAIT_CYCLES cycles in LO/HI, plus the DONE cycle.
REQ-024 Write data: SRAM_WDATA = captured data [15:0] in LO and [31:16] in HI.
REQ-025 Write strobe: SRAM_WE_N = 0 during a write in LO/HI, except on the final cycle of each phase; otherwise 1.
REQ-026 Read capture: on the final cycle of LO, register SRAM_RDATA into Rdata[15:0]; on the final cycle of HI, into Rdata[31:16].
- Rdata holds until the next load overwrites it.
- Writes leave Rdata unchanged.
REQ-027 DONE: ready = 1 for exactly one cycle, then go to IDLE unconditionally.
- Requests seen in DONE are ignored, because they belong to the completing instruction.
REQ-028 freeze = 1 in LO and HI, and in IDLE while a request is present; otherwise 0.
- freeze is combinational from state and request inputs.
REQ-029 Back-to-back accesses: after DONE, a request present in IDLE starts the next access in that same IDLE cycle, with freeze = 1.
REQ-030 Request inputs are sampled only in IDLE; changes during LO/HI have no effect.

Reset
REQ-031 rst low forces, asynchronously:
- state = IDLE, counter = 0
- Rdata = 0, captured registers = 0
- ready = 0, SRAM_WE_N = 1, SRAM_ADDR = 0, SRAM_WDATA = 0
REQ-032 freeze is forced to 0 while rst is low.
REQ-033 Reset during LO/HI aborts the access with no Rdata update; a partial SRAM write is permitted.

Structure
REQ-034 A shared package holds:
- the FSM state enumeration (2-bit encoding)
- ADDR_BASE default
- the half-word width constant
REQ-035 One sub-module, sram_wait_counter: a 4-bit counter with clear, increment enable and a terminal flag (count == WAIT_CYCLES-1).
REQ-036 All outputs except freeze are registered.

Verification
REQ-037 Load, WAIT_CYCLES=4: ALU_Res=1024 with MEM_R_EN held; SRAM returns 0x1234 at addr 0 and 0xABCD at addr 1 -> freeze high for 9 cycles, ready pulses in cycle 10, Rdata = 0xABCD1234.
REQ-038 Store: ALU_Res=1032, Val_Rm=0xDEADBEEF -> SRAM_ADDR 4 with WDATA 0xBEEF, then addr 5 with 0xDEAD; WE_N low 3 cycles per phase; Rdata unchanged.
REQ-039 Both enables set: MEM_R_EN = MEM_W_EN = 1 -> write sequence performed, Rdata unchanged.
REQ-040 Back-to-back: load immediately followed by a store -> second access starts in the IDLE cycle after DONE, giving two ready pulses 10 cycles apart.
REQ-041 Reset mid-HI: rst low during HI -> immediately IDLE, freeze 0, WE_N 1, Rdata 0; a new load after release completes normally.
REQ-042 Wrap: ALU_Res=1020 -> word index 0x3FFFFFFF truncated, SRAM_ADDR = 0x3FFFE then 0x3FFFF.

Source files
------------

// File: rtl/sram_access_ctrl_pkg.sv
// Shared types and constants for the 16-bit SRAM access controller.
package sram_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned ADDR_BASE_DEF = 32'd1024;
    localparam int          HW_W          = 16;
    localparam int          CNT_W         = 4;

endpackage

// File: rtl/sram_access_ctrl_wait_counter.sv
// Per-phase wait counter: clears or increments, flags the last cycle of a phase.
module sram_wait_counter
    import sram_access_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = (cnt == LAST);

endmodule

// File: rtl/sram_access_ctrl.sv
// Splits 32-bit CPU loads/stores into two timed 16-bit SRAM phases and
// holds the pipeline until the access completes.
module sram_access_ctrl
    import sram_access_ctrl_pkg::*;
#(
    parameter int          WAIT_CYCLES = 4,
    parameter int unsigned ADDR_BASE   = ADDR_BASE_DEF,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_Res,
    input  logic [31:0]        Val_Rm,
    output logic [31:0]        Rdata,
    output logic               ready,
    output logic               freeze,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [HW_W-1:0]    SRAM_WDATA,
    input  logic [HW_W-1:0]    SRAM_RDATA,
    output logic               SRAM_WE_N
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t           state;
    logic [31:0]      addr_q;
    logic [31:0]      data_q;
    logic             wr_q;
    logic [CNT_W-1:0] cnt;
    logic             term;
    logic             in_phase;
    logic             req;
    logic             nxt_last;

    function automatic logic [SRAM_AW-2:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return off[SRAM_AW:2];
    endfunction

    assign in_phase = (state == ST_LO) || (state == ST_HI);
    assign req      = MEM_R_EN || MEM_W_EN;
    // Next cycle is the last of the phase: strobe must already be released.
    assign nxt_last = !term && ((cnt + 1'b1) == LAST);
    assign freeze   = rst && (in_phase || ((state == ST_IDLE) && req));

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk (clk),
        .rst (rst),
        .clr (!in_phase || term),
        .inc (in_phase),
        .cnt (cnt),
        .term(term)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            Rdata      <= '0;
            ready      <= 1'b0;
            SRAM_WE_N  <= 1'b1;
            SRAM_ADDR  <= '0;
            SRAM_WDATA <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q     <= ALU_Res;
                        data_q     <= Val_Rm;
                        wr_q       <= MEM_W_EN;
                        SRAM_ADDR  <= {word_idx(ALU_Res), 1'b0};
                        SRAM_WDATA <= Val_Rm[HW_W-1:0];
                        SRAM_WE_N  <= !MEM_W_EN;
                        state      <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (term) begin
                        if (!wr_q) Rdata[HW_W-1:0] <= SRAM_RDATA;
                        SRAM_ADDR  <= {word_idx(addr_q), 1'b1};
                        SRAM_WDATA <= data_q[2*HW_W-1:HW_W];
                        SRAM_WE_N  <= !wr_q;
                        state      <= ST_HI;
                    end else begin
                        SRAM_WE_N <= !(wr_q && !nxt_last);
                    end
                end
                ST_HI: begin
                    if (term) begin
                        if (!wr_q) Rdata[2*HW_W-1:HW_W] <= SRAM_RDATA;
                        SRAM_WE_N <= 1'b1;
                        ready     <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        SRAM_WE_N <= !(wr_q && !nxt_last);
                    end
                end
                // Requests still visible here belong to the finishing instruction.
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with an Rdata scoreboard and SRAM write log.
module tb_sram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_Res;
    logic [31:0] Val_Rm;
    logic [31:0] Rdata;
    logic        ready;
    logic        freeze;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_WDATA;
    logic [15:0] SRAM_RDATA;
    logic        SRAM_WE_N;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          last_ready_cyc = 0;
    logic [31:0] rdata_model = 32'h0;
    logic [31:0] exp_q[$];
    logic [33:0] wr_log[$];

    sram_access_ctrl #(
        .WAIT_CYCLES(4),
        .ADDR_BASE  (1024),
        .SRAM_AW    (18)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MEM_R_EN  (MEM_R_EN),
        .MEM_W_EN  (MEM_W_EN),
        .ALU_Res   (ALU_Res),
        .Val_Rm    (Val_Rm),
        .Rdata     (Rdata),
        .ready     (ready),
        .freeze    (freeze),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_WDATA(SRAM_WDATA),
        .SRAM_RDATA(SRAM_RDATA),
        .SRAM_WE_N (SRAM_WE_N)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM read model: a few fixed words, an address-derived pattern elsewhere.
    always_comb begin
        case (SRAM_ADDR)
            18'h00000: SRAM_RDATA = 16'h1234;
            18'h00001: SRAM_RDATA = 16'hABCD;
            18'h3FFFE: SRAM_RDATA = 16'h1111;
            18'h3FFFF: SRAM_RDATA = 16'h2222;
            default:   SRAM_RDATA = SRAM_ADDR[15:0] ^ 16'h5A5A;
        endcase
    end

    always @(negedge clk) begin
        if (!SRAM_WE_N) wr_log.push_back({SRAM_ADDR, SRAM_WDATA});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] load_val,
                          input logic nr, input logic nw, input logic [31:0] na,
                          input logic [31:0] nd, input string tag);
        int          fc;
        int          rc;
        logic [17:0] alo;
        logic [17:0] ahi;
        logic [31:0] off;
        logic [31:0] e;
        @(negedge clk);
        MEM_R_EN = r;
        MEM_W_EN = w;
        ALU_Res  = a;
        Val_Rm   = d;
        if (w) begin
            exp_q.push_back(rdata_model);
        end else begin
            exp_q.push_back(load_val);
            rdata_model = load_val;
        end
        off = a - 32'd1024;
        fc  = 0;
        rc  = 0;
        alo = '0;
        ahi = '0;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (freeze) fc++;
            if (k == 2) alo = SRAM_ADDR;
            if (k == 6) ahi = SRAM_ADDR;
            if (ready) begin
                rc = k;
                last_ready_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        MEM_R_EN = nr;
        MEM_W_EN = nw;
        ALU_Res  = na;
        Val_Rm   = nd;
        e = exp_q.pop_front();
        chk({tag, "_freeze_cycles"}, 64'(fc), 64'd9);
        chk({tag, "_ready_cycle"}, 64'(rc), 64'd10);
        chk({tag, "_addr_lo"}, 64'(alo), 64'({off[18:2], 1'b0}));
        chk({tag, "_addr_hi"}, 64'(ahi), 64'({off[18:2], 1'b1}));
        chk({tag, "_rdata"}, 64'(Rdata), 64'(e));
    endtask

    initial begin
        int base;
        int r1;
        rst      = 1'b0;
        MEM_R_EN = 1'b1;
        MEM_W_EN = 1'b0;
        ALU_Res  = 32'd1024;
        Val_Rm   = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdata", 64'(Rdata), 64'h0);
        chk("rst_ready", 64'(ready), 64'h0);
        chk("rst_freeze", 64'(freeze), 64'h0);
        chk("rst_we_n", 64'(SRAM_WE_N), 64'h1);
        chk("rst_addr", 64'(SRAM_ADDR), 64'h0);
        chk("rst_wdata", 64'(SRAM_WDATA), 64'h0);
        @(negedge clk);
        MEM_R_EN = 1'b0;
        rst      = 1'b1;

        base = wr_log.size();
        access(1'b1, 1'b0, 32'd1024, 32'h0, 32'hABCD1234, 1'b0, 1'b0, 32'h0, 32'h0, "load0");
        chk("load0_no_writes", 64'(wr_log.size() - base), 64'd0);
        @(negedge clk);
        #1;
        chk("load0_ready_pulse_end", 64'(ready), 64'h0);
        chk("load0_freeze_idle", 64'(freeze), 64'h0);

        base = wr_log.size();
        access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "store");
        chk("store_wr_count", 64'(wr_log.size() - base), 64'd6);
        for (int i = 0; i < 6 && base + i < wr_log.size(); i++)
            chk("store_wr_entry", 64'(wr_log[base + i]),
                (i < 3) ? 64'({18'd4, 16'hBEEF}) : 64'({18'd5, 16'hDEAD}));

        base = wr_log.size();
        access(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "both");
        chk("both_wr_count", 64'(wr_log.size() - base), 64'd6);
        for (int i = 0; i < 6 && base + i < wr_log.size(); i++)
            chk("both_wr_entry", 64'(wr_log[base + i]),
                (i < 3) ? 64'({18'd8, 16'hF00D}) : 64'({18'd9, 16'hCAFE}));

        access(1'b1, 1'b0, 32'd1032, 32'h0, 32'h5A5F5A5E, 1'b0, 1'b0, 32'h0, 32'h0, "load4");

        access(1'b1, 1'b0, 32'd1040, 32'h0, 32'h5A535A52, 1'b0, 1'b1, 32'd1048, 32'h01234567, "b2b_load");
        r1 = last_ready_cyc;
        base = wr_log.size();
        access(1'b0, 1'b1, 32'd1048, 32'h01234567, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "b2b_store");
        chk("b2b_ready_gap", 64'(last_ready_cyc - r1), 64'd10);
        chk("b2b_wr_count", 64'(wr_log.size() - base), 64'd6);

        @(negedge clk);
        MEM_W_EN = 1'b1;
        ALU_Res  = 32'd1056;
        Val_Rm   = 32'h55AA33CC;
        repeat (6) @(negedge clk);
        #1;
        chk("midhi_freeze_before", 64'(freeze), 64'h1);
        chk("midhi_we_n_before", 64'(SRAM_WE_N), 64'h0);
        #2;
        rst = 1'b0;
        #1;
        rdata_model = 32'h0;
        chk("midhi_freeze", 64'(freeze), 64'h0);
        chk("midhi_we_n", 64'(SRAM_WE_N), 64'h1);
        chk("midhi_rdata", 64'(Rdata), 64'h0);
        chk("midhi_ready", 64'(ready), 64'h0);
        chk("midhi_addr", 64'(SRAM_ADDR), 64'h0);
        @(negedge clk);
        MEM_W_EN = 1'b0;
        rst      = 1'b1;
        access(1'b1, 1'b0, 32'd1024, 32'h0, 32'hABCD1234, 1'b0, 1'b0, 32'h0, 32'h0, "post_rst_load");

        access(1'b1, 1'b0, 32'd1020, 32'h0, 32'h22221111, 1'b0, 1'b0, 32'h0, 32'h0, "wrap");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
